ser_deshift: RTL and testbench
==============================

Name: ser_deshift

Overview:
- Serial-in/parallel-out frame receiver: the receiving end of the team's shift-register serial link.
- Collects N bits from a strobed serial line, starting at a start-of-frame marker.
- Shift direction is selectable per frame: MSB-first matches a left-shifting transmitter, LSB-first matches a right-shifting one.
- Completed words go into a one-deep holding register and are presented on a valid/ready interface to downstream logic, with overrun and short-frame error reporting.

Parameters:
- N, 8, word width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- sin  input  1  serial data bit, sampled only when sin_vld=1.
- sin_vld  input  1  bit strobe; one bit is consumed per cycle it is high.
- sin_sof  input  1  start of frame; qualified by sin_vld; marks the first bit of a word.
- dir  input  1  0 = MSB-first, 1 = LSB-first; sampled with the SOF bit, held for the frame.
- q  output  N  received word (holding register).
- q_vld  output  1  q holds an unconsumed word.
- q_rdy  input  1  downstream accepts q when q_vld & q_rdy.
- busy  output  1  a frame is in progress (state SHIFT).
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  clears ovr.
- sof_err  output  1  one-cycle pulse: frame aborted by an early SOF.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; shift register, bit count and q all 0; q_vld=0, busy=0, ovr=0, sof_err=0. Reset wins over every other input, including mid-frame; a partial frame is discarded.
- State IDLE:
  - sin_vld & sin_sof: load the first bit; latch dir into dir_r; cnt=1; go to SHIFT.
  - sin_vld without sin_sof: ignore the bit; stay in IDLE.
- Shift rule for each accepted bit:
  - dir_r=0: sh = {sh[N-2:0], sin}.
  - dir_r=1: sh = {sin, sh[N-1:1]}.
  - The first bit is shifted into a cleared register.
- State SHIFT:
  - sin_vld & !sin_sof: shift; cnt++.
  - On the bit that makes cnt=N: word complete; go to IDLE.
  - sin_vld=0: hold everything; no timeout.
  - sin_vld & sin_sof (early SOF):
    - Abort the current frame and pulse sof_err for one cycle.
    - Restart from that bit: clear sh, shift in sin, cnt=1, latch the new dir; stay in SHIFT.
- Word completion:
  - The completed word is the value of sh including the Nth bit.
  - It loads q and sets q_vld on the same edge, so q_vld is seen high the cycle after the last sin_vld.
  - Latency is therefore 1 clk after the last bit.
- Handshake:
  - q_vld clears on the edge where q_vld & q_rdy.
  - q and q_vld are stable while q_vld=1 and q_rdy=0.
  - Next frame: reception continues in the shift register while q is held; no back-pressure on the serial side.
- Overrun:
  - A word completes while q_vld=1 and q_rdy=0: the new word is dropped, q keeps the old word, and ovr is set.
  - Completion and acceptance in the same cycle (q_vld & q_rdy): the new word loads q, q_vld stays 1, and ovr is not set.
- ovr clearing:
  - ovr stays set until ovr_clr=1.
  - If ovr_clr and a new overrun occur in the same cycle, set wins.
- busy = (state==SHIFT).
- Arithmetic: cnt is $clog2(N+1) bits wide and never exceeds N.

Test Plan:
- Reset behaviour: assert rst=0 mid-frame after 3 bits, then release and send a full frame → all outputs 0 after reset; the partial bits do not appear in q; the next frame decodes correctly.
- MSB-first decode, N=8, dir=0: send bits 1,0,1,1,0,0,1,0 with sin_vld continuous → q=8'hB2 and q_vld=1 one cycle after the 8th bit; busy high for the cycles in SHIFT.
- LSB-first decode with gaps, dir=1: send the same bit sequence with sin_vld de-asserted on random cycles → q=8'h4D; gaps do not change the result.
- Back-to-back frames with handshake:
  - Frame 8'hA5, then frame 8'h3C, with q_rdy=0 until after the second completes → q stays A5, ovr=1, and after q_rdy one transfer of A5 occurs.
  - Then ovr_clr → ovr=0.
  - Repeat with q_rdy pulsed exactly on the completion cycle of the second frame → q=3C, q_vld stays 1, ovr stays 0.
- Early SOF: a new SOF after 5 bits, then a full 8-bit frame with dir=0 and value 8'hFF → sof_err pulses exactly one cycle; q=8'hFF; no partial word emitted.
- Ignore-in-IDLE: sin_vld pulses without sin_sof while idle → no state change, busy=0, q_vld=0.

Source files
------------

// File: rtl/ser_deshift.sv
// ser_deshift: serial-in/parallel-out frame receiver.
// Collects N strobed bits starting at a start-of-frame marker, MSB-first or
// LSB-first per frame. Completed words land in a one-deep holding register
// presented on a valid/ready interface, with sticky overrun and a one-cycle
// pulse when a frame is aborted by an early start-of-frame.
module ser_deshift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_vld,
    input  logic         sin_sof,
    input  logic         dir,
    output logic [N-1:0] q,
    output logic         q_vld,
    input  logic         q_rdy,
    output logic         busy,
    output logic         ovr,
    input  logic         ovr_clr,
    output logic         sof_err
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:0]   sh_q;
    logic [N-1:0]   sh_d;
    logic [N-1:0]   sh_base;
    logic [CW-1:0]  cnt_q;
    logic           dir_q;
    logic           dir_use;
    logic [N-1:0]   word_q;
    logic           q_vld_q;
    logic           ovr_q;
    logic           sof_err_q;
    logic           word_done;
    logic           q_free;

    // Shifted value for the bit on the line; a SOF bit (or the first bit out
    // of IDLE) is shifted into a cleared register using the freshly sampled dir.
    always_comb begin
        sh_base   = (state_q == IDLE || sin_sof) ? '0 : sh_q;
        dir_use   = sin_sof ? dir : dir_q;
        sh_d      = dir_use ? {sin, sh_base[N-1:1]} : {sh_base[N-2:0], sin};
        word_done = (state_q == SHIFT) && sin_vld && !sin_sof
                    && (cnt_q == CW'(N - 1));
        q_free    = !q_vld_q || q_rdy;
    end

    // Frame FSM, holding register, handshake and error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            word_q    <= '0;
            q_vld_q   <= 1'b0;
            ovr_q     <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            sof_err_q <= 1'b0;

            if (sin_vld) begin
                case (state_q)
                    IDLE: begin
                        // Bits without SOF while idle are dropped.
                        if (sin_sof) begin
                            sh_q    <= sh_d;
                            dir_q   <= dir;
                            cnt_q   <= CW'(1);
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sin_sof) begin
                            // Early SOF: abandon the partial word, restart here.
                            sh_q      <= sh_d;
                            dir_q     <= dir;
                            cnt_q     <= CW'(1);
                            sof_err_q <= 1'b1;
                        end else if (word_done) begin
                            sh_q    <= sh_d;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            sh_q  <= sh_d;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                endcase
            end

            // A finished word loads q only if the slot is empty or being
            // drained this cycle; otherwise it is dropped and q is kept.
            if (word_done) begin
                if (q_free) begin
                    word_q  <= sh_d;
                    q_vld_q <= 1'b1;
                end
            end else if (q_vld_q && q_rdy) begin
                q_vld_q <= 1'b0;
            end

            // Overrun is sticky; a new overrun beats a simultaneous clear.
            if (word_done && !q_free) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign q       = word_q;
    assign q_vld   = q_vld_q;
    assign busy    = (state_q == SHIFT);
    assign ovr     = ovr_q;
    assign sof_err = sof_err_q;

endmodule

// File: tb/tb_ser_deshift.sv
// Testbench for ser_deshift: table-driven frames, hand-written corner
// sequences and a randomized run, all compared every cycle against a
// frame-level reference model built from a queue of received bits.
module tb_ser_deshift;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         sin;
    logic         sin_vld;
    logic         sin_sof;
    logic         dir;
    logic [N-1:0] q;
    logic         q_vld;
    logic         q_rdy;
    logic         busy;
    logic         ovr;
    logic         ovr_clr;
    logic         sof_err;

    int checks = 0;
    int errors = 0;

    ser_deshift #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .sin     (sin),
        .sin_vld (sin_vld),
        .sin_sof (sin_sof),
        .dir     (dir),
        .q       (q),
        .q_vld   (q_vld),
        .q_rdy   (q_rdy),
        .busy    (busy),
        .ovr     (ovr),
        .ovr_clr (ovr_clr),
        .sof_err (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits of the current frame are collected in a queue and
    // the word is assembled arithmetically once N bits have arrived.
    bit           m_bits[$];
    bit           m_dir;
    bit           m_busy;
    logic [N-1:0] m_q;
    bit           m_qv;
    bit           m_ovr;
    bit           m_serr;

    task automatic model_update();
        bit           done;
        bit           ovr_set;
        logic [N-1:0] word;
        done = 0;
        word = '0;
        if (!rst) begin
            m_bits.delete();
            m_busy = 0; m_dir = 0; m_q = '0; m_qv = 0; m_ovr = 0; m_serr = 0;
        end else begin
            m_serr = 0;
            if (sin_vld) begin
                if (sin_sof) begin
                    if (m_busy) m_serr = 1;
                    m_bits.delete();
                    m_bits.push_back(sin);
                    m_dir  = dir;
                    m_busy = 1;
                end else if (m_busy) begin
                    m_bits.push_back(sin);
                    if (m_bits.size() == N) begin
                        for (int i = 0; i < N; i++) begin
                            if (m_dir) word[i] = m_bits[i];
                            else       word[N-1-i] = m_bits[i];
                        end
                        done = 1;
                        m_bits.delete();
                        m_busy = 0;
                    end
                end
            end
            ovr_set = done && m_qv && !q_rdy;
            if (done) begin
                if (!m_qv || q_rdy) begin
                    m_q  = word;
                    m_qv = 1;
                end
            end else if (m_qv && q_rdy) begin
                m_qv = 0;
            end
            if (ovr_set)      m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare.
    task automatic step(input logic r, input logic v, input logic s, input logic d,
                        input logic b, input logic rdy, input logic clr);
        rst = r; sin_vld = v; sin_sof = s; dir = d; sin = b; q_rdy = rdy; ovr_clr = clr;
        @(posedge clk);
        model_update();
        #1;
        chk("q",       32'(q),       32'(m_q));
        chk("q_vld",   32'(q_vld),   32'(m_qv));
        chk("busy",    32'(busy),    32'(m_busy));
        chk("ovr",     32'(ovr),     32'(m_ovr));
        chk("sof_err", 32'(sof_err), 32'(m_serr));
    endtask

    // Send one frame; seq[N-1] goes out first. rdy_last drives q_rdy on the
    // final bit only; gaps inserts random idle strobes between bits.
    task automatic send_frame(input logic [N-1:0] seq, input logic d,
                              input logic rdy_last, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(2);
                for (int k = 0; k < g; k++) step(1, 0, 0, 0, 0, 0, 0);
            end
            step(1, 1, (i == 0), d, seq[N-1-i], (i == N - 1) ? rdy_last : 1'b0, 0);
        end
    endtask

    typedef struct {
        logic         d;
        logic [N-1:0] seq;
        logic [N-1:0] exp;
        bit           gaps;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 8'b1011_0010, 8'hB2, 1'b0};
        vecs[1] = '{1'b1, 8'b1011_0010, 8'h4D, 1'b1};
        vecs[2] = '{1'b0, 8'hA5, 8'hA5, 1'b1};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 1'b0};
        vecs[4] = '{1'b1, 8'hF0, 8'h0F, 1'b1};
        vecs[5] = '{1'b0, 8'hFF, 8'hFF, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 8'hC8, 8'h13, 1'b0};

        // Reset state.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 1, 1);
        chk("rst_q", 32'(q), 0);
        chk("rst_q_vld", 32'(q_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        $display("reset: q=%0h q_vld=%0b busy=%0b ovr=%0b", q, q_vld, busy, ovr);

        // Reset mid-frame after 3 bits, then a clean frame.
        step(1, 1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_q_vld", 32'(q_vld), 0);
        send_frame(8'b1011_0010, 0, 0, 0);
        chk("after_rst_q", 32'(q), 32'h B2);
        $display("mid-frame reset then frame: q=%0h", q);
        step(1, 0, 0, 0, 0, 1, 0);

        // Table-driven frames.
        foreach (vecs[i]) begin
            send_frame(vecs[i].seq, vecs[i].d, 0, vecs[i].gaps);
            chk("tbl_q", 32'(q), 32'(vecs[i].exp));
            chk("tbl_q_vld", 32'(q_vld), 1);
            $display("vec %0d dir=%0b seq=%0h q=%0h exp=%0h", i, vecs[i].d, vecs[i].seq, q, vecs[i].exp);
            step(1, 0, 0, 0, 0, 1, 0);
        end

        // Overrun: second frame completes while the first is still held.
        send_frame(8'hA5, 0, 0, 1);
        send_frame(8'h3C, 0, 0, 1);
        chk("ovr_q", 32'(q), 32'h A5);
        chk("ovr_set", 32'(ovr), 1);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("ovr_drain", 32'(q_vld), 0);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("ovr_one_xfer", 32'(q_vld), 0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("ovr_clr", 32'(ovr), 0);
        $display("overrun: q held A5, ovr set then cleared");

        // Completion coinciding with acceptance.
        send_frame(8'hA5, 0, 0, 0);
        send_frame(8'h3C, 0, 1, 0);
        chk("same_cyc_q", 32'(q), 32'h 3C);
        chk("same_cyc_qv", 32'(q_vld), 1);
        chk("same_cyc_ovr", 32'(ovr), 0);
        $display("accept on completion: q=%0h ovr=%0b", q, ovr);

        // Overrun with a simultaneous clear: set wins.
        for (int i = 0; i < N; i++)
            step(1, 1, (i == 0), 0, 1'b1, 0, (i == N - 1));
        chk("set_wins", 32'(ovr), 1);
        step(1, 0, 0, 0, 0, 1, 1);
        chk("clr_after", 32'(ovr), 0);
        $display("overrun with clear same cycle: set wins");

        // Early SOF after 5 bits, then a full FF frame.
        for (int i = 0; i < 5; i++) step(1, 1, (i == 0), 1, 1'b0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0);
        chk("sof_err_pulse", 32'(sof_err), 1);
        for (int i = 1; i < N; i++) begin
            step(1, 1, 0, 0, 1, 0, 0);
            if (i == 1) chk("sof_err_one", 32'(sof_err), 0);
            if (i < N - 1) chk("early_no_word", 32'(q_vld), 0);
        end
        chk("early_q", 32'(q), 32'h FF);
        $display("early SOF: q=%0h", q);
        step(1, 0, 0, 0, 0, 1, 0);

        // Strobes without SOF while idle are ignored.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, i[0], 1, 0, 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_qv", 32'(q_vld), 0);
        end
        $display("idle strobes ignored");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic r, v, s;
            r = ($urandom_range(199) != 0);
            v = ($urandom_range(9) < 7);
            s = v && (m_busy ? ($urandom_range(24) == 0) : ($urandom_range(2) == 0));
            step(r, v, s, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(3) == 0), ($urandom_range(9) == 0));
        end
        $display("random run done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
